// File: rtl/bicubic_out_serializer.sv
// Bicubic output serializer: turns 4-pixel upsampler beats into a
// one-pixel-per-cycle stream with frame/row markers.
module bicubic_out_serializer #(
  parameter int CHANNEL_WIDTH  = 8,
  parameter int BLOCK_SIZE     = 960,
  parameter int SRC_IMG_HEIGHT = 540
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     bcci_rsp_valid,
  output logic                     bf_rsp_ready,
  input  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data1,
  input  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data2,
  input  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data3,
  input  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data4,
  output logic                     ac_tvalid,
  input  logic                     ac_tready,
  output logic [CHANNEL_WIDTH-1:0] ac_tdata,
  output logic                     ac_tuser,
  output logic                     ac_tlast,
  output logic                     frame_done
);

  localparam int COLS = 4 * BLOCK_SIZE;
  localparam int ROWS = 4 * SRC_IMG_HEIGHT;
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int EW   = 4 * CHANNEL_WIDTH;

  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);

  logic [EW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic [1:0]    sub_idx;
  logic [CW-1:0] col;
  logic [RW-1:0] row;

  logic          in_hsk;
  logic          out_hsk;
  logic          pop;
  logic          col_last;
  logic          row_last;
  logic [EW-1:0] head;

  assign bf_rsp_ready = (count != 2'd2);
  assign ac_tvalid    = (count != 2'd0);

  assign in_hsk  = bcci_rsp_valid && bf_rsp_ready;
  assign out_hsk = ac_tvalid && ac_tready;
  assign pop     = out_hsk && (sub_idx == 2'd3);

  assign col_last = (col == COL_MAX);
  assign row_last = (row == ROW_MAX);

  assign ac_tlast = ac_tvalid && col_last;
  assign ac_tuser = ac_tvalid && (col == '0) && (row == '0);

  // Storage carries no reset; the output mux masks it while empty.
  always_ff @(posedge clk) begin
    if (in_hsk) begin
      mem[wr_ptr] <= {bcci_rsp_data4, bcci_rsp_data3,
                      bcci_rsp_data2, bcci_rsp_data1};
    end
  end

  assign head = mem[rd_ptr];

  always_comb begin
    ac_tdata = '0;
    if (ac_tvalid) begin
      unique case (sub_idx)
        2'd0: ac_tdata = head[0*CHANNEL_WIDTH +: CHANNEL_WIDTH];
        2'd1: ac_tdata = head[1*CHANNEL_WIDTH +: CHANNEL_WIDTH];
        2'd2: ac_tdata = head[2*CHANNEL_WIDTH +: CHANNEL_WIDTH];
        2'd3: ac_tdata = head[3*CHANNEL_WIDTH +: CHANNEL_WIDTH];
        default: ac_tdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      sub_idx <= 2'd0;
    end else begin
      if (in_hsk) wr_ptr <= ~wr_ptr;
      if (pop) rd_ptr <= ~rd_ptr;
      if (out_hsk) sub_idx <= sub_idx + 2'd1;
      unique case ({in_hsk, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_hsk && col_last && row_last;
      if (out_hsk) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bicubic_out_serializer.sv
// Bench for bicubic_out_serializer: pixel-queue model plus directed
// literal checks, with 8 pixels/row and 4 rows/frame.
module tb_bicubic_out_serializer;

  localparam int PPR = 8;
  localparam int PPF = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bcci_rsp_valid = 1'b0;
  logic       bf_rsp_ready;
  logic [7:0] d1 = '0, d2 = '0, d3 = '0, d4 = '0;
  logic       ac_tvalid;
  logic       ac_tready = 1'b0;
  logic [7:0] ac_tdata;
  logic       ac_tuser;
  logic       ac_tlast;
  logic       frame_done;

  always #5 clk = ~clk;

  bicubic_out_serializer #(
    .CHANNEL_WIDTH (8),
    .BLOCK_SIZE    (2),
    .SRC_IMG_HEIGHT(1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bcci_rsp_valid(bcci_rsp_valid),
    .bf_rsp_ready  (bf_rsp_ready),
    .bcci_rsp_data1(d1),
    .bcci_rsp_data2(d2),
    .bcci_rsp_data3(d3),
    .bcci_rsp_data4(d4),
    .ac_tvalid     (ac_tvalid),
    .ac_tready     (ac_tready),
    .ac_tdata      (ac_tdata),
    .ac_tuser      (ac_tuser),
    .ac_tlast      (ac_tlast),
    .frame_done    (frame_done)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Model: flat pixel queue, pixel index since reset.
  logic [7:0] mq[$];
  int  idx = 0;
  bit  fd_exp = 0;
  int  out_cnt = 0;
  int  tlast_cnt = 0;
  int  fd_cnt = 0;
  int  fd_cyc = 0;
  int  hsk_cyc[$];
  int  tuser_q[$];

  always @(negedge clk) begin
    int beats;
    if (!rst_n) begin
      chk("rst_tvalid", ac_tvalid, 0);
      chk("rst_tdata", ac_tdata, 0);
      chk("rst_ready", bf_rsp_ready, 1);
      chk("rst_tuser", ac_tuser, 0);
      chk("rst_tlast", ac_tlast, 0);
      chk("rst_frame_done", frame_done, 0);
      mq.delete();
      idx = 0;
      fd_exp = 0;
    end else begin
      beats = (mq.size() + 3) / 4;
      chk("frame_done", frame_done, fd_exp);
      if (frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
      chk("tvalid", ac_tvalid, mq.size() != 0);
      chk("ready", bf_rsp_ready, beats != 2);
      if (mq.size() != 0) begin
        chk("tdata", ac_tdata, mq[0]);
        chk("tuser", ac_tuser, (idx % PPF) == 0);
        chk("tlast", ac_tlast, (idx % PPR) == PPR - 1);
      end
      fd_exp = 0;
      if (mq.size() != 0 && ac_tready) begin
        void'(mq.pop_front());
        if ((idx % PPF) == PPF - 1) fd_exp = 1;
        if (ac_tuser) tuser_q.push_back(idx);
        if (ac_tlast) tlast_cnt++;
        hsk_cyc.push_back(cyc);
        idx++;
        out_cnt++;
      end
      if (bcci_rsp_valid && beats != 2) begin
        mq.push_back(d1);
        mq.push_back(d2);
        mq.push_back(d3);
        mq.push_back(d4);
      end
    end
  end

  bit   rnd_ready = 0;
  logic ready_fix = 1'b1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) ac_tready = 1'($urandom_range(0, 1));
      else ac_tready = ready_fix;
    end
  end

  task automatic send_beat(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] e,
                           input bit rnd);
    bit acc = 0;
    int n = 0;
    if (rnd) begin
      repeat ($urandom_range(0, 1)) begin
        bcci_rsp_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    bcci_rsp_valid = 1'b1;
    d1 = a;
    d2 = b;
    d3 = c;
    d4 = e;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = bf_rsp_ready;
      @(posedge clk);
      #1;
      n++;
    end
    chk("send_timeout", acc, 1);
  endtask

  task automatic drain();
    int n = 0;
    bcci_rsp_valid = 1'b0;
    while (mq.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", mq.size() == 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bcci_rsp_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    int tb_base;
    int fd_base;
    int tl_base;
    int n;
    ready_fix = 1'b1;
    #2;
    chk("init_tvalid", ac_tvalid, 0);
    chk("init_ready", bf_rsp_ready, 1);
    do_reset();

    // Single beat, four pixels on consecutive cycles
    send_beat(8'h11, 8'h22, 8'h33, 8'h44, 0);
    bcci_rsp_valid = 1'b0;
    chk("b1_tvalid", ac_tvalid, 1);
    chk("b1_p0", ac_tdata, 8'h11);
    chk("b1_tuser0", ac_tuser, 1);
    @(posedge clk); #1;
    chk("b1_p1", ac_tdata, 8'h22);
    chk("b1_tuser1", ac_tuser, 0);
    @(posedge clk); #1;
    chk("b1_p2", ac_tdata, 8'h33);
    @(posedge clk); #1;
    chk("b1_p3", ac_tdata, 8'h44);
    @(posedge clk); #1;
    chk("b1_empty", ac_tvalid, 0);
    chk("b1_empty_data", ac_tdata, 0);

    // Full frame streamed back to back
    do_reset();
    base = hsk_cyc.size();
    fd_base = fd_cnt;
    tl_base = tlast_cnt;
    for (int b = 0; b < 8; b++)
      send_beat(8'(b*4+1), 8'(b*4+2), 8'(b*4+3), 8'(b*4+4), 0);
    drain();
    repeat (2) @(posedge clk);
    #1;
    chk("frm_pixels", hsk_cyc.size() - base, 32);
    chk("frm_nogap", hsk_cyc[base+31] - hsk_cyc[base], 31);
    chk("frm_tlast", tlast_cnt - tl_base, 4);
    chk("frm_done_cnt", fd_cnt - fd_base, 1);
    chk("frm_done_cyc", fd_cyc, hsk_cyc[base+31] + 1);

    // Backpressure with two beats buffered
    ready_fix = 1'b0;
    do_reset();
    base = out_cnt;
    send_beat(8'h51, 8'h52, 8'h53, 8'h54, 0);
    send_beat(8'h61, 8'h62, 8'h63, 8'h64, 0);
    bcci_rsp_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_ready", bf_rsp_ready, 0);
      chk("bp_hold", ac_tdata, 8'h51);
    end
    ready_fix = 1'b1;
    drain();
    chk("bp_count", out_cnt - base, 8);

    // Random valid/ready across three frames
    do_reset();
    rnd_ready = 1;
    base = out_cnt;
    tb_base = tuser_q.size();
    for (int b = 0; b < 24; b++)
      send_beat(8'(b*4), 8'(b*4+1), 8'(b*4+2), 8'(b*4+3), 1);
    rnd_ready = 0;
    drain();
    chk("rnd_count", out_cnt - base, 96);
    chk("rnd_tuser_n", tuser_q.size() - tb_base, 3);
    if (tuser_q.size() - tb_base == 3) begin
      chk("rnd_tuser0", tuser_q[tb_base], 0);
      chk("rnd_tuser1", tuser_q[tb_base+1], 32);
      chk("rnd_tuser2", tuser_q[tb_base+2], 64);
    end

    // Reset mid-frame after pixel 13
    do_reset();
    base = out_cnt;
    for (int b = 0; b < 4; b++)
      send_beat(8'(8'h80+b*4), 8'(8'h81+b*4), 8'(8'h82+b*4),
                8'(8'h83+b*4), 0);
    bcci_rsp_valid = 1'b0;
    n = 0;
    while (out_cnt - base < 13 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reach13", out_cnt - base, 13);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_tvalid", ac_tvalid, 0);
    chk("mid_tdata", ac_tdata, 0);
    chk("mid_ready", bf_rsp_ready, 1);
    chk("mid_tuser", ac_tuser, 0);
    chk("mid_tlast", ac_tlast, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_beat(8'hA1, 8'hA2, 8'hA3, 8'hA4, 0);
    bcci_rsp_valid = 1'b0;
    chk("mid_new_data", ac_tdata, 8'hA1);
    chk("mid_new_tuser", ac_tuser, 1);
    drain();

    // Push coinciding with the pop of the last sub-pixel
    do_reset();
    send_beat(8'hC1, 8'hC2, 8'hC3, 8'hC4, 0);
    bcci_rsp_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pp_last_sub", ac_tdata, 8'hC4);
    send_beat(8'hD1, 8'hD2, 8'hD3, 8'hD4, 0);
    bcci_rsp_valid = 1'b0;
    chk("pp_tvalid", ac_tvalid, 1);
    chk("pp_data", ac_tdata, 8'hD1);
    chk("pp_ready", bf_rsp_ready, 1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bicubic_out_serializer.md
BICUBIC_OUT_SERIALIZER -- requirements
Module: bicubic_out_serializer

Interface
REQ-001 SHALL have parameter CHANNEL_WIDTH, default 8, giving the width of one pixel channel.
REQ-002 SHALL have parameter BLOCK_SIZE, default 960, giving the source columns per row; each row carries BLOCK_SIZE input beats.
REQ-003 SHALL have parameter SRC_IMG_HEIGHT, default 540, giving the source rows; each frame carries 4*SRC_IMG_HEIGHT output rows.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: clk  input  1  clock; rst_n  input  1  asynchronous reset, active low.
REQ-005 bcci_rsp_valid  input  1  upsampler beat valid.
REQ-006 bf_rsp_ready  output  1  serializer can accept a beat.
REQ-007 bcci_rsp_data1..bcci_rsp_data4  input  CHANNEL_WIDTH each  four horizontally adjacent upscaled pixels, left to right.
REQ-008 ac_tvalid  output  1  output pixel valid.
REQ-009 ac_tready  input  1  downstream accepts pixel.
REQ-010 ac_tdata  output  CHANNEL_WIDTH  output pixel.
REQ-011 ac_tuser  output  1  first pixel of frame.
REQ-012 ac_tlast  output  1  last pixel of row.
REQ-013 frame_done  output  1  single-cycle pulse after the final pixel of a frame.

Function
REQ-014 SHALL accept an input beat when bcci_rsp_valid && bf_rsp_ready (in_hsk) and emit a pixel when ac_tvalid && ac_tready (out_hsk).
REQ-015 SHALL store input beats in a 2-entry FIFO, each entry 4*CHANNEL_WIDTH wide, with registered read/write pointers and count.
REQ-016 bf_rsp_ready SHALL equal (count != 2), derived from registers only, with no combinational path from ac_tready.
REQ-017 SHALL allow push and pop in the same cycle when count is 1; count stays 1.
REQ-018 ac_tvalid SHALL equal (count != 0).
REQ-019 ac_tdata SHALL be head entry pixel sub_idx, where sub_idx 0..3 selects data1..data4.
REQ-020 sub_idx SHALL advance on out_hsk and wrap 3->0; the head entry SHALL be popped on out_hsk with sub_idx==3.
REQ-021 Latency: a beat accepted into an empty FIFO in cycle N SHALL produce ac_tvalid=1 with its data1 in cycle N+1.
REQ-022 Throughput: with ac_tready held at 1 and input always valid, SHALL emit one pixel every cycle with no bubbles.
REQ-023 While ac_tvalid=1 and ac_tready=0, ac_tdata, ac_tuser and ac_tlast SHALL hold stable.
REQ-024 A column counter col (0..4*BLOCK_SIZE-1) SHALL increment on out_hsk and wrap to 0 after 4*BLOCK_SIZE-1.
REQ-025 A row counter row (0..4*SRC_IMG_HEIGHT-1) SHALL increment when col wraps and wrap to 0 after the last row.
REQ-026 ac_tlast SHALL equal ac_tvalid && (col == 4*BLOCK_SIZE-1).
REQ-027 ac_tuser SHALL equal ac_tvalid && col==0 && row==0.
REQ-028 frame_done SHALL be registered and go high for exactly one cycle after the out_hsk where col and row are both at their maximum.
REQ-029 Counter widths SHALL be $clog2(4*BLOCK_SIZE) and $clog2(4*SRC_IMG_HEIGHT) bits, with no overflow.
REQ-030 Data SHALL pass unmodified, with no arithmetic on pixel values.

Reset
REQ-031 On rst_n low, asynchronously: count=0, pointers=0, sub_idx=0, col=0, row=0, frame_done=0.
REQ-032 During reset: ac_tvalid=0, ac_tlast=0, ac_tuser=0, bf_rsp_ready=1, ac_tdata=0.
REQ-033 Reset asserted mid-frame SHALL discard buffered beats; the next frame restarts at col=0, row=0 with ac_tuser on its first pixel.
REQ-034 FIFO storage need not be reset, but ac_tdata SHALL read 0 whenever count==0.

Verification (params BLOCK_SIZE=2, SRC_IMG_HEIGHT=1: 8 pixels/row, 4 rows/frame)
REQ-035 Single beat {0x11,0x22,0x33,0x44}, ac_tready=1 -> ac_tdata 0x11,0x22,0x33,0x44 on cycles N+1..N+4; ac_tuser=1 on 0x11 only.
REQ-036 Continuous valid, ready=1 -> 32 consecutive pixels with no gaps; ac_tlast on pixels 8,16,24,32; frame_done pulses once, on the cycle after pixel 32.
REQ-037 ac_tready=0 for 10 cycles after two beats are accepted -> bf_rsp_ready=0, ac_tdata stays at the first beat's data1; on release the pixels resume in order with no loss.
REQ-038 Random valid/ready (50%) across 3 frames -> output pixel stream equals input pixels flattened in order; ac_tuser appears at indices 0, 32, 64.
REQ-039 rst_n pulsed low after pixel 13 -> all outputs return to their reset values immediately; the next beat's data1 comes out with ac_tuser=1.
REQ-040 count=1, in_hsk and the final-pixel out_hsk in the same cycle -> count stays 1 and the new beat's data1 is presented the next cycle.
